pay_collect: RTL

- Payment-collection stage directly downstream of the mode/state controller.
- While the controller's state bus reads PAYMENT, it:
  - accepts coin pulses and accumulates the inserted amount;
  - compares the total against the order total;
  - produces the one-cycle finish pulse the controller consumes, with a success/fail flag.
- Also computes change/refund and holds results for the SUCCESS/FAILURE display states.

---
 rtl/pay_pkg.sv | 30 +++
 rtl/pay_collect_sec_tick.sv | 33 +++
 rtl/pay_collect.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pay_pkg.sv
// pay_pkg -- shared definitions for the payment-collection stage.
//   * Controller state-bus encodings (OFF, PAYMENT, SUCCESS, FAILURE).
//   * Collection FSM encoding (P_IDLE, P_COLLECT, P_DONE).
//   * coin_value(): maps the 2-bit coin selector to its value in yuan.
package pay_pkg;

  localparam logic [3:0] ST_OFF     = 4'b0000;
  localparam logic [3:0] ST_PAYMENT = 4'b0010;
  localparam logic [3:0] ST_SUCCESS = 4'b0110;
  localparam logic [3:0] ST_FAILURE = 4'b0111;

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_COLLECT = 2'd1,
    P_DONE    = 2'd2
  } pstate_t;

  // Coin selector to value: 00=1, 01=5, 10=10, 11=20.
  function automatic logic [4:0] coin_value(input logic [1:0] sel);
    logic [4:0] val;
    unique case (sel)
      2'b00:   val = 5'd1;
      2'b01:   val = 5'd5;
      2'b10:   val = 5'd10;
      default: val = 5'd20;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/pay_collect_sec_tick.sv
// sec_tick -- one-second tick generator for the payment timeout.
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : count enable; the divider clears whenever en is low
//   tick       : one-cycle pulse every CLK_HZ cycles while en is high
module sec_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pay_collect.sv
// pay_collect -- payment-collection stage downstream of the mode/state controller.
// While the controller sits in PAYMENT it accumulates coins, compares the total
// against the order price and issues a one-cycle finish pulse with a pay_ok flag
// (1=paid, 0=refunded). Change/refund and the paid amount are held afterwards for
// the SUCCESS/FAILURE display states.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   state       : controller state bus (OFF/PAYMENT/SUCCESS/FAILURE, others = override)
//   price       : order total, sampled on entry to PAYMENT
//   coin_vld    : one-cycle coin pulse, value selected by coin_sel
//   cancel      : one-cycle user return request
//   finish      : one-cycle pulse, payment concluded
//   pay_ok      : outcome, valid with finish and held afterwards
//   paid        : amount inserted so far
//   change      : change (success) or refund (failure)
//   secs_left   : seconds remaining before the idle timeout
//   coin_rej    : one-cycle pulse, coin not accepted
//
// Build option: define PAY_TIMEOUT_EN to include the 1 s divider and the idle
// timeout refund. Without it secs_left is tied to 0 and only cancel or a
// controller exit ends collection with a refund.
module pay_collect
  import pay_pkg::*;
#(
  parameter int AMT_W     = 10,
  parameter int CLK_HZ    = 100_000_000,
  parameter int TIMEOUT_S = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       state,
  input  logic [AMT_W-1:0] price,
  input  logic             coin_vld,
  input  logic [1:0]       coin_sel,
  input  logic             cancel,
  output logic             finish,
  output logic             pay_ok,
  output logic [AMT_W-1:0] paid,
  output logic [AMT_W-1:0] change,
  output logic [5:0]       secs_left,
  output logic             coin_rej
);

  pstate_t          fsm;
  logic [3:0]       state_q;
  logic [AMT_W-1:0] price_q;
  logic [AMT_W:0]   sum;
  logic [AMT_W-1:0] paid_nxt;
  logic             collecting;
  logic             entry;
  logic             coin_ok;
  logic             tick;
  logic             timeout;

  assign collecting = (fsm == P_COLLECT);
  assign entry      = (state == ST_PAYMENT) && (state_q != ST_PAYMENT);

  // One extra bit catches a coin that would push the total past 2^AMT_W-1;
  // such a coin is rejected rather than clipped.
  assign sum      = {1'b0, paid} + (AMT_W+1)'(coin_value(coin_sel));
  assign coin_ok  = coin_vld && !sum[AMT_W] && collecting && (state == ST_PAYMENT);
  assign paid_nxt = coin_ok ? sum[AMT_W-1:0] : paid;

`ifdef PAY_TIMEOUT_EN
  localparam logic [5:0] SECS_INIT = 6'(TIMEOUT_S);

  sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (collecting),
    .tick (tick)
  );

  // A coin on the tick cycle reloads the timer, so it cancels the timeout.
  assign timeout = tick && !coin_ok && (secs_left <= 6'd1);
`else
  localparam logic [5:0] SECS_INIT = 6'd0;

  assign tick    = 1'b0;
  assign timeout = 1'b0;
`endif

  // NOTE: every register, including price_q, is in the async reset so the
  // outputs are defined the moment rst_n falls, with no clock required.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= P_IDLE;
      state_q   <= ST_OFF;
      price_q   <= '0;
      paid      <= '0;
      change    <= '0;
      pay_ok    <= 1'b0;
      finish    <= 1'b0;
      coin_rej  <= 1'b0;
      secs_left <= SECS_INIT;
    end else begin
      state_q  <= state;
      finish   <= 1'b0;
      coin_rej <= coin_vld && !coin_ok;

      if (state == ST_OFF) begin
        fsm       <= P_IDLE;
        price_q   <= '0;
        paid      <= '0;
        change    <= '0;
        pay_ok    <= 1'b0;
        coin_rej  <= 1'b0;
        secs_left <= SECS_INIT;
      end else begin
        unique case (fsm)
          P_IDLE: begin
            if (entry) begin
              price_q   <= price;
              paid      <= '0;
              change    <= '0;
              pay_ok    <= 1'b0;
              secs_left <= SECS_INIT;
              fsm       <= P_COLLECT;
            end
          end

          P_COLLECT: begin
            if (state != ST_PAYMENT) begin
              // Controller override: refund whatever has been inserted.
              finish <= 1'b1;
              pay_ok <= 1'b0;
              change <= paid;
              fsm    <= P_DONE;
            end else begin
              paid <= paid_nxt;
              if (coin_ok) begin
                secs_left <= SECS_INIT;
              end else if (tick && secs_left != 6'd0) begin
                secs_left <= secs_left - 6'd1;
              end
              // The coin of this cycle counts before cancel/timeout is judged.
              if (paid_nxt >= price_q) begin
                finish <= 1'b1;
                pay_ok <= 1'b1;
                change <= paid_nxt - price_q;
                fsm    <= P_DONE;
              end else if (cancel || timeout) begin
                finish <= 1'b1;
                pay_ok <= 1'b0;
                change <= paid_nxt;
                fsm    <= P_DONE;
              end
            end
          end

          P_DONE: begin
            if (!(state inside {ST_PAYMENT, ST_SUCCESS, ST_FAILURE})) begin
              fsm <= P_IDLE;
            end
          end

          default: fsm <= P_IDLE;
        endcase
      end
    end
  end

endmodule
